snake_mmio_responder: RTL and testbench

- Memory-mapped responder on the processor's data-memory port, alongside dmem.
- Captures processor stores to a small address window into a 12-word shadow bank.
- Copies the shadow bank into the 384-bit snake_data display bus on a frame boundary, and only after the processor requests a commit.
- Answers processor loads from the window with dmem-compatible timing, so software can read back state and poll commit status.

---
 rtl/snake_mmio_responder_if.sv | 28 ++
 rtl/snake_mmio_responder.sv | 129 ++++++++++++
 tb/tb_snake_mmio_responder.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/snake_mmio_responder_if.sv
// Processor data-memory port as seen by the snake display responder.
// The processor side drives the address, store data and enable; the responder answers loads.
interface snake_mmio_responder_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] address_dmem;
  logic [DATA_WIDTH-1:0] data;
  logic                  wren;
  logic [DATA_WIDTH-1:0] q_mmio;
  logic                  hit;

  modport master (
    output address_dmem,
    output data,
    output wren,
    input  q_mmio,
    input  hit
  );

  modport slave (
    input  address_dmem,
    input  data,
    input  wren,
    output q_mmio,
    output hit
  );
endinterface

// File: rtl/snake_mmio_responder.sv
// Shadow-bank responder on the dmem port: stores land in a shadow bank, and a requested
// commit copies the bank onto the snake_data display bus at the next frame_sync rising edge.
module snake_mmio_responder #(
  parameter int                    ADDR_WIDTH = 12,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_WORDS  = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 12'hF00
) (
  input  logic                            clock,
  input  logic                            reset,
  snake_mmio_responder_if.slave           bus,
  input  logic                            frame_sync,
  output logic [NUM_WORDS*DATA_WIDTH-1:0] snake_data,
  output logic                            commit_pending,
  output logic [15:0]                     frame_count
);

  localparam logic [ADDR_WIDTH-1:0] WINDOW_WORDS = ADDR_WIDTH'(NUM_WORDS);
  localparam int                    BUS_WIDTH    = NUM_WORDS * DATA_WIDTH;

  logic [DATA_WIDTH-1:0] shadow_q [NUM_WORDS];
  logic [DATA_WIDTH-1:0] shadow_d [NUM_WORDS];
  logic [BUS_WIDTH-1:0]  snake_data_q, snake_data_d;
  logic                  commit_pending_q, commit_pending_d;
  logic [15:0]           frame_count_q, frame_count_d;
  logic                  fs_prev_q, fs_prev_d;
  logic [DATA_WIDTH-1:0] q_mmio_q, q_mmio_d;
  logic                  hit_q, hit_d;

  logic [ADDR_WIDTH-1:0] offset;
  logic                  shadow_hit;
  logic                  ctrl_hit;
  logic                  store_shadow;
  logic                  store_ctrl;
  logic                  fs_edge;
  logic                  commit;
  logic [BUS_WIDTH-1:0]  shadow_flat;

  // Unsigned offset wraps for addresses below the base, so a single compare bounds the window.
  always_comb begin
    offset       = bus.address_dmem - BASE_ADDR;
    shadow_hit   = (offset < WINDOW_WORDS);
    ctrl_hit     = (offset == WINDOW_WORDS);
    store_shadow = bus.wren & shadow_hit;
    store_ctrl   = bus.wren & ctrl_hit;
    fs_edge      = frame_sync & ~fs_prev_q;
    commit       = fs_edge & commit_pending_q;
    fs_prev_d    = frame_sync;
  end

  always_comb begin
    shadow_flat = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      shadow_flat[i*DATA_WIDTH +: DATA_WIDTH] = shadow_q[i];
    end
  end

  always_comb begin
    shadow_d = shadow_q;
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (store_shadow && (offset == ADDR_WIDTH'(i))) begin
        shadow_d[i] = bus.data;
      end
    end
  end

  // A control store in the commit cycle overrides the commit's own clear of the pending flag.
  always_comb begin
    snake_data_d     = snake_data_q;
    commit_pending_d = commit_pending_q;
    frame_count_d    = frame_count_q;
    if (commit) begin
      snake_data_d     = shadow_flat;
      commit_pending_d = 1'b0;
      frame_count_d    = frame_count_q + 16'd1;
    end
    if (store_ctrl) begin
      commit_pending_d = bus.data[0];
    end
  end

  always_comb begin
    q_mmio_d = '0;
    hit_d    = shadow_hit | ctrl_hit;
    if (shadow_hit) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        if (offset == ADDR_WIDTH'(i)) begin
          q_mmio_d = shadow_q[i];
        end
      end
    end else if (ctrl_hit) begin
      q_mmio_d = DATA_WIDTH'({frame_count_q, 15'b0, commit_pending_q});
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      shadow_q         <= '{default: '0};
      snake_data_q     <= '0;
      commit_pending_q <= 1'b0;
      frame_count_q    <= '0;
      fs_prev_q        <= 1'b0;
    end else begin
      shadow_q         <= shadow_d;
      snake_data_q     <= snake_data_d;
      commit_pending_q <= commit_pending_d;
      frame_count_q    <= frame_count_d;
      fs_prev_q        <= fs_prev_d;
    end
  end

  // Read port sits on the inverted clock like dmem's syncram, so loads resolve in the same cycle.
  always_ff @(negedge clock) begin
    if (reset) begin
      q_mmio_q <= '0;
      hit_q    <= 1'b0;
    end else begin
      q_mmio_q <= q_mmio_d;
      hit_q    <= hit_d;
    end
  end

  assign snake_data     = snake_data_q;
  assign commit_pending = commit_pending_q;
  assign frame_count    = frame_count_q;
  assign bus.q_mmio     = q_mmio_q;
  assign bus.hit        = hit_q;

endmodule

// File: tb/tb_snake_mmio_responder.sv
// Directed bench for snake_mmio_responder: window stores, commit on frame edges,
// simultaneous-event priority, frame_count wrap and reset while a commit is pending.
module tb_snake_mmio_responder;

  logic         clock;
  logic         reset;
  logic         frame_sync;
  logic [383:0] snake_data;
  logic         commit_pending;
  logic [15:0]  frame_count;

  int checks;
  int errors;

  snake_mmio_responder_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus_if ();

  snake_mmio_responder dut (
    .clock          (clock),
    .reset          (reset),
    .bus            (bus_if),
    .frame_sync     (frame_sync),
    .snake_data     (snake_data),
    .commit_pending (commit_pending),
    .frame_count    (frame_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic store_word(input logic [11:0] addr, input logic [31:0] value);
    bus_if.address_dmem = addr;
    bus_if.data         = value;
    bus_if.wren         = 1'b1;
    step();
    bus_if.wren         = 1'b0;
    bus_if.address_dmem = 12'h000;
    bus_if.data         = 32'h0;
  endtask

  // Leaves the bench just after the falling edge that captured the load.
  task automatic load_word(input logic [11:0] addr);
    bus_if.address_dmem = addr;
    bus_if.wren         = 1'b0;
    @(negedge clock);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [383:0] observed,
                              input logic [383:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    checks              = 0;
    errors              = 0;
    reset               = 1'b1;
    frame_sync          = 1'b0;
    bus_if.address_dmem = 12'h000;
    bus_if.data         = 32'h0;
    bus_if.wren         = 1'b0;

    // Reset then idle
    step();
    step();
    reset = 1'b0;
    repeat (3) step();
    check_output("reset_snake_data", snake_data, '0);
    check_output("reset_pending", 384'(commit_pending), 384'(1'b0));
    check_output("reset_frame_count", 384'(frame_count), 384'(16'h0));
    load_word(12'h000);
    check_output("reset_hit", 384'(bus_if.hit), 384'(1'b0));
    check_output("reset_q_mmio", 384'(bus_if.q_mmio), 384'(32'h0));

    // Shadow stores, frame pulse without commit, out-of-window stores ignored
    store_word(12'hF00, 32'h0005_0007);
    store_word(12'hF0B, 32'hDEAD_BEEF);
    store_word(12'hF0D, 32'h0000_0001);
    store_word(12'hEFF, 32'h0000_0001);
    frame_sync = 1'b1;
    step();
    frame_sync = 1'b0;
    step();
    check_output("no_commit_snake_data", snake_data, '0);
    check_output("no_commit_frame_count", 384'(frame_count), 384'(16'h0));
    check_output("outside_store_pending", 384'(commit_pending), 384'(1'b0));
    load_word(12'hF0B);
    check_output("load_f0b_hit", 384'(bus_if.hit), 384'(1'b1));
    check_output("load_f0b_q", 384'(bus_if.q_mmio), 384'(32'hDEAD_BEEF));
    load_word(12'hF00);
    check_output("load_f00_q", 384'(bus_if.q_mmio), 384'(32'h0005_0007));
    load_word(12'hF0D);
    check_output("load_f0d_hit", 384'(bus_if.hit), 384'(1'b0));
    check_output("load_f0d_q", 384'(bus_if.q_mmio), 384'(32'h0));
    load_word(12'hEFF);
    check_output("load_eff_hit", 384'(bus_if.hit), 384'(1'b0));

    // Request and apply a commit
    store_word(12'hF0C, 32'h0000_0001);
    check_output("request_pending", 384'(commit_pending), 384'(1'b1));
    load_word(12'hF0C);
    check_output("ctrl_read_pending", 384'(bus_if.q_mmio), 384'(32'h0000_0001));
    frame_sync = 1'b1;
    step();
    check_output("commit_word0", 384'(snake_data[31:0]), 384'(32'h0005_0007));
    check_output("commit_word11", 384'(snake_data[383:352]), 384'(32'hDEAD_BEEF));
    check_output("commit_word1", 384'(snake_data[63:32]), 384'(32'h0));
    check_output("commit_pending_clr", 384'(commit_pending), 384'(1'b0));
    check_output("commit_frame_count", 384'(frame_count), 384'(16'd1));
    load_word(12'hF0C);
    check_output("ctrl_read_count", 384'(bus_if.q_mmio), 384'(32'h0001_0000));

    // frame_sync held high: no further edges
    store_word(12'hF0C, 32'h0000_0001);
    repeat (5) step();
    check_output("held_high_no_copy", 384'(frame_count), 384'(16'd1));
    check_output("held_high_pending", 384'(commit_pending), 384'(1'b1));
    frame_sync = 1'b0;
    step();
    frame_sync = 1'b1;
    repeat (5) step();
    check_output("held_high_one_copy", 384'(frame_count), 384'(16'd2));
    check_output("held_high_pending_clr", 384'(commit_pending), 384'(1'b0));
    store_word(12'hF0C, 32'h0000_0001);
    repeat (3) step();
    check_output("held_high_later_req", 384'(frame_count), 384'(16'd2));
    frame_sync = 1'b0;
    step();

    // Shadow store in the commit cycle: copy takes old contents
    frame_sync = 1'b1;
    store_word(12'hF00, 32'h1111_1111);
    check_output("same_cycle_old_word0", 384'(snake_data[31:0]), 384'(32'h0005_0007));
    check_output("same_cycle_count", 384'(frame_count), 384'(16'd3));
    load_word(12'hF00);
    check_output("same_cycle_shadow", 384'(bus_if.q_mmio), 384'(32'h1111_1111));
    frame_sync = 1'b0;
    step();
    store_word(12'hF0C, 32'h0000_0001);
    frame_sync = 1'b1;
    step();
    check_output("next_commit_word0", 384'(snake_data[31:0]), 384'(32'h1111_1111));
    check_output("next_commit_count", 384'(frame_count), 384'(16'd4));

    // Control store racing a commit
    frame_sync = 1'b0;
    step();
    store_word(12'hF0C, 32'h0000_0001);
    frame_sync = 1'b1;
    store_word(12'hF0C, 32'h0000_0001);
    check_output("ctrl1_commit_count", 384'(frame_count), 384'(16'd5));
    check_output("ctrl1_commit_pending", 384'(commit_pending), 384'(1'b1));
    frame_sync = 1'b0;
    step();
    frame_sync = 1'b1;
    store_word(12'hF0C, 32'h0000_0000);
    check_output("ctrl0_commit_count", 384'(frame_count), 384'(16'd6));
    check_output("ctrl0_commit_pending", 384'(commit_pending), 384'(1'b0));
    frame_sync = 1'b0;
    step();
    store_word(12'hF01, 32'hABCD_0123);
    frame_sync = 1'b1;
    store_word(12'hF0C, 32'h0000_0001);
    check_output("late_req_no_copy", 384'(snake_data[63:32]), 384'(32'h0));
    check_output("late_req_count", 384'(frame_count), 384'(16'd6));
    check_output("late_req_pending", 384'(commit_pending), 384'(1'b1));

    // frame_count wrap
    force dut.frame_count_d = 16'hFFFF;
    step();
    release dut.frame_count_d;
    check_output("preload_count", 384'(frame_count), 384'(16'hFFFF));
    frame_sync = 1'b0;
    step();
    frame_sync = 1'b1;
    step();
    check_output("wrap_count", 384'(frame_count), 384'(16'h0000));
    check_output("wrap_word1", 384'(snake_data[63:32]), 384'(32'hABCD_0123));

    // Reset with a commit pending
    frame_sync = 1'b0;
    step();
    store_word(12'hF0C, 32'h0000_0001);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_output("mid_reset_pending", 384'(commit_pending), 384'(1'b0));
    check_output("mid_reset_snake_data", snake_data, '0);
    check_output("mid_reset_count", 384'(frame_count), 384'(16'h0));
    frame_sync = 1'b1;
    step();
    step();
    check_output("post_reset_no_copy", snake_data, '0);
    check_output("post_reset_count", 384'(frame_count), 384'(16'h0));
    load_word(12'hF0B);
    check_output("post_reset_shadow_hit", 384'(bus_if.hit), 384'(1'b1));
    check_output("post_reset_shadow_q", 384'(bus_if.q_mmio), 384'(32'h0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
